// File: rtl/corevx_cache_tlb_if.sv
// -----------------------------------------------------------------------------
// corevx_cache_tlb_if
// Command/response bundle between a TLB client (page table walker, cache
// pipeline) and corevx_cache_tlb.
//   tlb_cmd            : 00 NONE, 01 RESOLVE, 10 WRITE, 11 INVALIDATE_ALL
//   virtual_address    : Sv32 VPN (index in low bits, tag in high bits)
//   accesstag_w        : PTE flags {D,A,G,U,X,W,R,V} stored on WRITE
//   phys_w             : physical page number stored on WRITE
//   tlb_busy           : invalidate sweep in progress
//   tlb_read_hit       : result of the last accepted RESOLVE
//   tlb_read_accesstag : access tag of the hitting way, 0 on miss
//   tlb_read_ptag      : PPN of the hitting way, 0 on miss
//   tlb_perf_hits/misses : RESOLVE statistics, present only when
//                          COREVX_TLB_PERF_EN is defined
// -----------------------------------------------------------------------------
interface corevx_cache_tlb_if;
   logic [1:0]  tlb_cmd;
   logic [19:0] virtual_address;
   logic [7:0]  accesstag_w;
   logic [21:0] phys_w;
   logic        tlb_busy;
   logic        tlb_read_hit;
   logic [7:0]  tlb_read_accesstag;
   logic [21:0] tlb_read_ptag;
`ifdef COREVX_TLB_PERF_EN
   logic [31:0] tlb_perf_hits;
   logic [31:0] tlb_perf_misses;
`endif

   modport master (
      output tlb_cmd, virtual_address, accesstag_w, phys_w,
      input  tlb_busy, tlb_read_hit, tlb_read_accesstag, tlb_read_ptag
`ifdef COREVX_TLB_PERF_EN
      , tlb_perf_hits, tlb_perf_misses
`endif
   );

   modport slave (
      input  tlb_cmd, virtual_address, accesstag_w, phys_w,
      output tlb_busy, tlb_read_hit, tlb_read_accesstag, tlb_read_ptag
`ifdef COREVX_TLB_PERF_EN
      , tlb_perf_hits, tlb_perf_misses
`endif
   );
endinterface

// File: rtl/corevx_cache_tlb.sv
// -----------------------------------------------------------------------------
// corevx_cache_tlb
// Set-associative TLB caching leaf Sv32 PTE results (PPN + 8-bit access tag).
// RESOLVE returns registered hit/ptag/accesstag one cycle later; WRITE fills
// (match -> lowest invalid -> round-robin victim); INVALIDATE_ALL sweeps one
// set per cycle while tlb_busy is high.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : corevx_cache_tlb_if.slave (command, write data, read results)
// Optional feature macro: COREVX_TLB_PERF_EN adds saturating hit/miss
// counters on bus.tlb_perf_hits / bus.tlb_perf_misses.
// -----------------------------------------------------------------------------
module corevx_cache_tlb #(
   parameter int ENTRIES_W = 4,
   parameter int WAYS_W    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   corevx_cache_tlb_if.slave bus
);
   localparam int SETS  = 1 << ENTRIES_W;
   localparam int WAYS  = 1 << WAYS_W;
   localparam int TAG_W = 20 - ENTRIES_W;

   localparam logic [1:0] CMD_RESOLVE = 2'b01;
   localparam logic [1:0] CMD_WRITE   = 2'b10;
   localparam logic [1:0] CMD_INVAL   = 2'b11;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t               state_r, state_nxt_s;
   logic                 busy_r;
   logic [ENTRIES_W-1:0] flush_idx_r;
   logic [WAYS-1:0]      valid_r  [SETS];
   logic [WAYS_W-1:0]    victim_r [SETS];
   logic [TAG_W-1:0]     tag_r    [SETS][WAYS];
   logic [7:0]           at_r     [SETS][WAYS];
   logic [21:0]          ppn_r    [SETS][WAYS];

   logic                 read_hit_r;
   logic [7:0]           read_at_r;
   logic [21:0]          read_ptag_r;

   logic [ENTRIES_W-1:0] idx_s;
   logic [TAG_W-1:0]     vtag_s;
   logic                 idle_s, resolve_s, write_s, inval_s;
   logic                 hit_s, inv_found_s, use_victim_s;
   logic [WAYS_W-1:0]    hit_way_s, inv_way_s, wr_way_s;

   assign idx_s     = bus.virtual_address[ENTRIES_W-1:0];
   assign vtag_s    = bus.virtual_address[19:ENTRIES_W];
   // Commands are only accepted in IDLE; anything issued during a sweep is dropped.
   assign idle_s    = (state_r == ST_IDLE);
   assign resolve_s = idle_s && (bus.tlb_cmd == CMD_RESOLVE);
   // A WRITE with V=0 is ignored entirely, including the victim counter.
   assign write_s   = idle_s && (bus.tlb_cmd == CMD_WRITE) && bus.accesstag_w[0];
   assign inval_s   = idle_s && (bus.tlb_cmd == CMD_INVAL);

   // Way lookup: scanning downward lets the lowest matching/invalid way win.
   always_comb begin
      hit_s       = 1'b0;
      hit_way_s   = {WAYS_W{1'b0}};
      inv_found_s = 1'b0;
      inv_way_s   = {WAYS_W{1'b0}};
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_r[idx_s][w] && (tag_r[idx_s][w] == vtag_s)) begin
            hit_s     = 1'b1;
            hit_way_s = WAYS_W'(w);
         end else begin
            hit_s     = hit_s;
            hit_way_s = hit_way_s;
         end
         if (!valid_r[idx_s][w]) begin
            inv_found_s = 1'b1;
            inv_way_s   = WAYS_W'(w);
         end else begin
            inv_found_s = inv_found_s;
            inv_way_s   = inv_way_s;
         end
      end
   end

   // Fill-way selection: overwrite a match, else lowest invalid, else the victim.
   always_comb begin
      wr_way_s     = victim_r[idx_s];
      use_victim_s = 1'b0;
      if (hit_s) begin
         wr_way_s = hit_way_s;
      end else if (inv_found_s) begin
         wr_way_s = inv_way_s;
      end else begin
         wr_way_s     = victim_r[idx_s];
         use_victim_s = 1'b1;
      end
   end

   // FSM next-state: IDLE -> FLUSH on INVALIDATE_ALL, back after the last set.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (inval_s) state_nxt_s = ST_FLUSH;
            else         state_nxt_s = ST_IDLE;
         end
         ST_FLUSH: begin
            if (&flush_idx_r) state_nxt_s = ST_IDLE;
            else              state_nxt_s = ST_FLUSH;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state register and registered busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == ST_FLUSH);
      end
   end

   // Valid flops, victim counters and sweep index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            valid_r[s]  <= {WAYS{1'b0}};
            victim_r[s] <= {WAYS_W{1'b0}};
         end
         flush_idx_r <= {ENTRIES_W{1'b0}};
      end else if (state_r == ST_FLUSH) begin
         valid_r[flush_idx_r] <= {WAYS{1'b0}};
         flush_idx_r          <= flush_idx_r + ENTRIES_W'(1'b1);
      end else if (inval_s) begin
         flush_idx_r <= {ENTRIES_W{1'b0}};
      end else if (write_s) begin
         valid_r[idx_s][wr_way_s] <= 1'b1;
         if (use_victim_s) begin
            victim_r[idx_s] <= victim_r[idx_s] + WAYS_W'(1'b1);
         end
      end
   end

   // Entry payload storage; qualified by the valid flops, so no reset needed.
   always_ff @(posedge clk) begin
      if (write_s) begin
         tag_r[idx_s][wr_way_s] <= vtag_s;
         at_r[idx_s][wr_way_s]  <= bus.accesstag_w;
         ppn_r[idx_s][wr_way_s] <= bus.phys_w;
      end
   end

   // Registered RESOLVE results; cleared when a sweep starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_hit_r  <= 1'b0;
         read_at_r   <= 8'h00;
         read_ptag_r <= 22'h0;
      end else if (resolve_s) begin
         read_hit_r  <= hit_s;
         read_at_r   <= hit_s ? at_r[idx_s][hit_way_s]  : 8'h00;
         read_ptag_r <= hit_s ? ppn_r[idx_s][hit_way_s] : 22'h0;
      end else if (inval_s) begin
         read_hit_r  <= 1'b0;
         read_at_r   <= 8'h00;
         read_ptag_r <= 22'h0;
      end
   end

   assign bus.tlb_busy           = busy_r;
   assign bus.tlb_read_hit       = read_hit_r;
   assign bus.tlb_read_accesstag = read_at_r;
   assign bus.tlb_read_ptag      = read_ptag_r;

`ifdef COREVX_TLB_PERF_EN
   logic [31:0] perf_hits_r;
   logic [31:0] perf_misses_r;

   // Saturating hit/miss counters, one increment per accepted RESOLVE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_hits_r   <= 32'h0;
         perf_misses_r <= 32'h0;
      end else if (resolve_s) begin
         if (hit_s) begin
            if (perf_hits_r != 32'hFFFF_FFFF) perf_hits_r <= perf_hits_r + 32'd1;
         end else begin
            if (perf_misses_r != 32'hFFFF_FFFF) perf_misses_r <= perf_misses_r + 32'd1;
         end
      end
   end

   assign bus.tlb_perf_hits   = perf_hits_r;
   assign bus.tlb_perf_misses = perf_misses_r;
`else
   // Performance counters are not built in this configuration.
`endif
endmodule
